// File: rtl/uart_tx_sched_if.sv
// Requester-side and transmitter-side signals of the shared UART transmit scheduler.
// A byte on slice i moves when req_valid[i] and req_ready[i] are both high at a rising clk edge;
// a requester keeps req_data stable while req_valid is high and may drop req_valid before acceptance.
interface uart_tx_sched_if #(
  parameter int NREQ         = 4,
  parameter int PAYLOAD_BITS = 8
) ();
  logic [NREQ-1:0]              req_valid;
  logic [NREQ*PAYLOAD_BITS-1:0] req_data;
  logic [NREQ-1:0]              req_lock;
  logic [NREQ-1:0]              req_ready;
  logic                         tx_en;
  logic [PAYLOAD_BITS-1:0]      tx_data;
  logic                         tx_busy;
  logic [NREQ-1:0]              grant;
  logic [NREQ-1:0]              lock_owner;
  logic                         err_timeout;

  modport master (
    output req_valid, req_data, req_lock, tx_busy,
    input  req_ready, tx_en, tx_data, grant, lock_owner, err_timeout
  );

  modport slave (
    input  req_valid, req_data, req_lock, tx_busy,
    output req_ready, tx_en, tx_data, grant, lock_owner, err_timeout
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among NREQ requesters, with per-requester
// message lock, one-cycle send strobe and a timeout on the transmitter's busy handshake.
module uart_tx_sched #(
  parameter int NREQ         = 4,
  parameter int PAYLOAD_BITS = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic       clk,
  input  logic       resetn,
  uart_tx_sched_if.slave bus,
  output logic [1:0] dbg_state
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(BUSY_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_WAIT_BUSY = 2'd2,
    S_WAIT_DONE = 2'd3
  } state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [CW-1:0]   cnt;
  logic [NREQ-1:0] sel;
  logic [IW-1:0]   sel_idx;
  logic            found;
  int              idx;
  logic            transfer;

  // A held lock blocks everyone else, even while its owner has nothing to send.
  always_comb begin
    sel     = '0;
    sel_idx = '0;
    found   = 1'b0;
    idx     = 0;
    if (state == S_IDLE && !bus.tx_busy) begin
      if (|bus.lock_owner) begin
        sel = bus.lock_owner & bus.req_valid;
        for (int i = 0; i < NREQ; i++) begin
          if (bus.lock_owner[i]) sel_idx = IW'(i);
        end
      end else begin
        for (int k = 1; k <= NREQ; k++) begin
          idx = (int'(last) + k) % NREQ;
          if (!found && bus.req_valid[idx]) begin
            found    = 1'b1;
            sel[idx] = 1'b1;
            sel_idx  = IW'(idx);
          end
        end
      end
    end
  end

  assign bus.req_ready = sel;
  assign transfer      = |(sel & bus.req_valid);
  assign dbg_state     = state;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state           <= S_IDLE;
      last            <= IW'(NREQ - 1);
      cnt             <= '0;
      bus.tx_en       <= 1'b0;
      bus.tx_data     <= '0;
      bus.grant       <= '0;
      bus.lock_owner  <= '0;
      bus.err_timeout <= 1'b0;
    end else begin
      bus.tx_en       <= 1'b0;
      bus.err_timeout <= 1'b0;
      // Release first; a transfer in the same cycle overrides with its own lock sample.
      if (|(bus.lock_owner & ~bus.req_lock)) bus.lock_owner <= '0;
      case (state)
        S_IDLE: begin
          if (transfer) begin
            bus.tx_data    <= bus.req_data[sel_idx*PAYLOAD_BITS +: PAYLOAD_BITS];
            bus.grant      <= sel;
            last           <= sel_idx;
            bus.lock_owner <= bus.req_lock[sel_idx] ? sel : '0;
            bus.tx_en      <= 1'b1;
            state          <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= '0;
          state <= S_WAIT_BUSY;
        end
        S_WAIT_BUSY: begin
          if (bus.tx_busy) begin
            state <= S_WAIT_DONE;
          end else if (cnt == CW'(BUSY_TIMEOUT - 1)) begin
            bus.err_timeout <= 1'b1;
            bus.grant       <= '0;
            bus.lock_owner  <= '0;
            state           <= S_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT_DONE: begin
          if (!bus.tx_busy) begin
            bus.grant <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: transmitter busy model, scoreboard of {grant, byte} per tx_en.
module tb_uart_tx_sched;
  localparam int NREQ = 4;
  localparam int PB   = 8;

  logic       clk;
  logic       resetn;
  logic [1:0] dbg_state;

  uart_tx_sched_if #(.NREQ(NREQ), .PAYLOAD_BITS(PB)) bus ();

  uart_tx_sched #(.NREQ(NREQ), .PAYLOAD_BITS(PB), .BUSY_TIMEOUT(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  logic [NREQ+PB-1:0] exp_q[$];
  logic [NREQ+PB-1:0] e;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // transmitter model: busy rises the cycle after tx_en and stays high busy_len cycles
  int busy_len = 5;
  bit busy_en  = 1'b1;
  bit arm      = 1'b0;
  int left     = 0;
  always @(negedge clk) begin
    if (!resetn) begin
      bus.tx_busy = 1'b0;
      arm         = 1'b0;
      left        = 0;
    end else begin
      if (arm) begin
        arm         = 1'b0;
        bus.tx_busy = 1'b1;
        left        = busy_len - 1;
      end else if (left > 0) begin
        left--;
      end else begin
        bus.tx_busy = 1'b0;
      end
      if (bus.tx_en === 1'b1 && busy_en) arm = 1'b1;
    end
  end

  // scoreboard: every tx_en must match the oldest expected {grant, byte}
  always @(negedge clk) begin
    if (bus.tx_en === 1'b1) begin
      check("tx_en_while_busy", 32'(bus.tx_busy), 0);
      if (exp_q.size() == 0) begin
        check("tx_en_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("tx_data", 32'(bus.tx_data), 32'(e[PB-1:0]));
        check("tx_grant", 32'(bus.grant), 32'(e[NREQ+PB-1:PB]));
      end
    end
  end

  // driver tasks
  task automatic wait_accept(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      #1;
      if (|(bus.req_ready & bus.req_valid)) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) check({tag, "_accept_timeout"}, 0, 1);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (dbg_state == 2'd0 && bus.tx_busy == 1'b0) ok = 1'b1;
    end
    if (!ok) check({tag, "_idle_timeout"}, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    resetn        = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_lock  = '0;
    bus.tx_busy   = 1'b0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_state", 32'(dbg_state), 0);
    check("rst_tx_en", 32'(bus.tx_en), 0);
    check("rst_tx_data", 32'(bus.tx_data), 0);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_lock", 32'(bus.lock_owner), 0);
    check("rst_err", 32'(bus.err_timeout), 0);
    check("rst_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    resetn = 1'b1;

    // single byte from requester 2
    @(negedge clk);
    bus.req_valid[2]   = 1'b1;
    bus.req_data[23:16] = 8'h41;
    exp_q.push_back({4'b0100, 8'h41});
    #1;
    check("single_ready", 32'(bus.req_ready), 32'h4);
    wait_accept("single");
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("single_tx_en", 32'(bus.tx_en), 1);
    check("single_tx_data", 32'(bus.tx_data), 32'h41);
    check("single_grant_issue", 32'(bus.grant), 32'h4);
    @(negedge clk);
    @(negedge clk);
    #1;
    check("single_state_done", 32'(dbg_state), 3);
    check("single_grant_done", 32'(bus.grant), 32'h4);
    wait_idle("single");
    check("single_grant_idle", 32'(bus.grant), 0);

    // round robin among 0, 1, 3 from a fresh pointer
    do_reset();
    @(negedge clk);
    bus.req_data  = {8'h13, 8'h00, 8'h11, 8'h10};
    bus.req_valid = 4'b1011;
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back({4'b0001, 8'h10});
      exp_q.push_back({4'b0010, 8'h11});
      exp_q.push_back({4'b1000, 8'h13});
    end
    #1;
    check("rr_first_ready", 32'(bus.req_ready), 32'h1);
    for (int a = 0; a < 6; a++) begin
      wait_accept("rr");
      @(negedge clk);
    end
    bus.req_valid = '0;
    wait_idle("rr");
    check("rr_drained", exp_q.size(), 0);

    // lock: requester 1 sends three bytes while requester 0 waits
    @(negedge clk);
    bus.req_data        = '0;
    bus.req_data[15:8]  = 8'hAA;
    bus.req_valid[1]    = 1'b1;
    bus.req_lock[1]     = 1'b1;
    exp_q.push_back({4'b0010, 8'hAA});
    exp_q.push_back({4'b0010, 8'hBB});
    exp_q.push_back({4'b0010, 8'hCC});
    exp_q.push_back({4'b0001, 8'h05});
    wait_accept("lock1");
    @(negedge clk);
    #1;
    check("lock_owner_set", 32'(bus.lock_owner), 32'h2);
    bus.req_data[7:0]  = 8'h05;
    bus.req_valid[0]   = 1'b1;
    bus.req_data[15:8] = 8'hBB;
    wait_accept("lock2");
    @(negedge clk);
    bus.req_data[15:8] = 8'hCC;
    wait_accept("lock3");
    @(negedge clk);
    #1;
    check("lock_owner_held", 32'(bus.lock_owner), 32'h2);
    bus.req_lock[1]  = 1'b0;
    bus.req_valid[1] = 1'b0;
    @(negedge clk);
    #1;
    check("lock_owner_released", 32'(bus.lock_owner), 0);
    wait_accept("lock_req0");
    @(negedge clk);
    bus.req_valid = '0;
    wait_idle("lock");
    check("lock_drained", exp_q.size(), 0);

    // lock starvation hold: requester 2 keeps the lock with no data
    @(negedge clk);
    bus.req_data[23:16] = 8'h22;
    bus.req_valid[2]    = 1'b1;
    bus.req_lock[2]     = 1'b1;
    exp_q.push_back({4'b0100, 8'h22});
    wait_accept("hold_first");
    @(negedge clk);
    bus.req_valid[2] = 1'b0;
    wait_idle("hold_first");
    check("hold_lock_owner", 32'(bus.lock_owner), 32'h4);
    @(negedge clk);
    bus.req_data[7:0] = 8'h07;
    bus.req_valid[0]  = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      check("hold_ready", 32'(bus.req_ready), 0);
      check("hold_tx_en", 32'(bus.tx_en), 0);
      @(negedge clk);
    end
    exp_q.push_back({4'b0001, 8'h07});
    bus.req_lock[2] = 1'b0;
    wait_accept("hold_release");
    @(negedge clk);
    bus.req_valid = '0;
    wait_idle("hold");
    check("hold_drained", exp_q.size(), 0);

    // timeout: transmitter never raises busy
    busy_en = 1'b0;
    @(negedge clk);
    bus.req_data[31:24] = 8'h5A;
    bus.req_valid[3]    = 1'b1;
    bus.req_lock[3]     = 1'b1;
    exp_q.push_back({4'b1000, 8'h5A});
    wait_accept("to");
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    check("to_tx_en", 32'(bus.tx_en), 1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      #1;
      check($sformatf("to_err_k%0d", k), 32'(bus.err_timeout), (k == 5) ? 1 : 0);
      if (k == 5) begin
        check("to_state", 32'(dbg_state), 0);
        check("to_grant", 32'(bus.grant), 0);
        check("to_lock", 32'(bus.lock_owner), 0);
      end
    end
    bus.req_lock = '0;
    busy_en      = 1'b1;
    @(negedge clk);
    bus.req_data[15:8] = 8'h66;
    bus.req_valid[1]   = 1'b1;
    exp_q.push_back({4'b0010, 8'h66});
    #1;
    check("to_next_ready", 32'(bus.req_ready), 32'h2);
    wait_accept("to_next");
    @(negedge clk);
    bus.req_valid = '0;
    wait_idle("to_next");

    // reset during WAIT_DONE
    @(negedge clk);
    bus.req_data[7:0] = 8'h77;
    bus.req_valid[0]  = 1'b1;
    bus.req_lock[0]   = 1'b1;
    exp_q.push_back({4'b0001, 8'h77});
    wait_accept("mid");
    @(negedge clk);
    bus.req_valid = '0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      #1;
      if (dbg_state == 2'd3) ok = 1'b1;
    end
    check("mid_reach_done", 32'(ok), 1);
    check("mid_grant", 32'(bus.grant), 32'h1);
    check("mid_lock", 32'(bus.lock_owner), 32'h1);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    #1;
    check("mid_rst_grant", 32'(bus.grant), 0);
    check("mid_rst_lock", 32'(bus.lock_owner), 0);
    check("mid_rst_tx_en", 32'(bus.tx_en), 0);
    check("mid_rst_state", 32'(dbg_state), 0);
    bus.req_lock = '0;
    @(negedge clk);
    resetn = 1'b1;
    bus.req_data[7:0]   = 8'h30;
    bus.req_data[23:16] = 8'h32;
    bus.req_valid       = 4'b0101;
    exp_q.push_back({4'b0001, 8'h30});
    exp_q.push_back({4'b0100, 8'h32});
    #1;
    check("mid_prio_ready", 32'(bus.req_ready), 32'h1);
    wait_accept("mid_r0");
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    wait_accept("mid_r2");
    @(negedge clk);
    bus.req_valid = '0;
    wait_idle("mid");

    check("final_queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
Round-robin scheduler that shares one UART transmitter between NREQ byte-producing requesters (CPU console port, debug monitor, trace unit, ...). Each requester offers bytes on a valid/ready handshake. The scheduler picks one byte at a time, issues a one-cycle send strobe to the transmitter, and waits for the transmitter's busy flag to rise and then fall before it grants again. A per-requester lock keeps a multi-byte message from being interleaved with other requesters' bytes.

Parameters:
NREQ, 4, number of requesters (2..8)
PAYLOAD_BITS, 8, byte width; must match the transmitter
BUSY_TIMEOUT, 4, cycles allowed in WAIT_BUSY for tx_busy to rise

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
req_valid  in  NREQ  requester i has a byte on its data slice
req_data  in  NREQ*PAYLOAD_BITS  byte of requester i at [i*PAYLOAD_BITS +: PAYLOAD_BITS]
req_lock  in  NREQ  requester i asks to keep ownership after its current byte
req_ready  out  NREQ  one-hot; byte of requester i is accepted this cycle when req_valid[i] is also high
tx_en  out  1  one-cycle send strobe to the transmitter
tx_data  out  PAYLOAD_BITS  byte to send; valid while tx_en is high
tx_busy  in  1  transmitter busy flag
grant  out  NREQ  one-hot owner of the byte in flight; 0 when IDLE
lock_owner  out  NREQ  one-hot current lock holder; 0 when unlocked
err_timeout  out  1  one-cycle pulse: tx_busy failed to rise after tx_en

Behaviour:
- Clock and reset: clk, resetn synchronous active-low.
- Reset values: state IDLE; tx_en, tx_data, grant, lock_owner, err_timeout all 0. The round-robin pointer last resets to NREQ-1, so requester 0 has first priority.
- States and transitions:
  - IDLE:
    - Selection sel is computed combinationally.
    - If tx_busy is 1, there is no selection.
    - Else, if lock_owner is non-zero, sel = lock_owner when that requester's req_valid is high; otherwise there is no selection, and the scheduler waits without granting anyone else.
    - Else, sel = the first requester with req_valid high, searching from index last+1 and wrapping modulo NREQ.
    - req_ready = sel, asserted combinationally only in IDLE.
    - On a transfer (req_valid[sel] and req_ready[sel]):
      - latch tx_data from the selected slice;
      - set grant = sel;
      - set last = index of sel;
      - set lock_owner = sel if req_lock[sel] is 1 at that edge, else 0;
      - go to ISSUE.
  - ISSUE: tx_en = 1 for exactly this one cycle; go to WAIT_BUSY.
  - WAIT_BUSY:
    - A cycle counter starts at 0.
    - If tx_busy is 1, go to WAIT_DONE.
    - Else, if the counter reaches BUSY_TIMEOUT-1, pulse err_timeout for one cycle, clear grant and lock_owner, and go to IDLE.
  - WAIT_DONE: when tx_busy is 0, clear grant and go to IDLE. lock_owner is kept.
- Lock release:
  - In any state, if lock_owner[i] is set and req_lock[i] is 0, lock_owner clears on the next edge.
  - Release takes priority over a re-lock only when it is not coincident with a transfer. A transfer's own req_lock sample wins.
- Latency:
  - req_valid with the scheduler idle and tx_busy 0 gives req_ready in the same cycle.
  - tx_en follows 1 cycle after acceptance.
  - The transmitter raises busy 1 cycle after tx_en.
  - Minimum gap between acceptances = 1 + 1 + busy duration + 1 cycles.
- Stability: requesters hold req_data stable while req_valid is high until accepted. Dropping req_valid before acceptance is legal; nothing is issued for it.
- Simultaneous events:
  - Several valids in IDLE: only one is accepted, in round-robin order.
  - req_valid rising in the same cycle that WAIT_DONE exits is not accepted until the IDLE cycle.
- Reset mid-operation: returns to the reset state immediately, and no tx_en is generated in the reset cycle. Any byte in flight in the transmitter is the transmitter's concern (it resets on the same resetn).
- Width: counter is $clog2(BUSY_TIMEOUT)+1 bits. Index arithmetic wraps modulo NREQ.

Test Plan:
- Single byte: req_valid[2]=1 with data 0x41 and tx_busy low -> req_ready=0b0100 same cycle; tx_en=1 with tx_data=0x41 next cycle; grant=0b0100 until busy falls, then 0.
- Round-robin: requesters 0, 1, 3 continuously valid with data 0x10, 0x11, 0x13; busy model of 5 cycles -> accepted order 0, 1, 3, 0, 1, 3; exactly one tx_en per busy period.
- Lock: requester 1 sends 0xAA, 0xBB, 0xCC with req_lock=1 while requester 0 is also valid -> all three bytes go out before any byte of requester 0. Requester 1 then drops req_lock -> lock_owner returns to 0 and requester 0 is granted next.
- Lock starvation hold: lock held by requester 2 with its valid low for 20 cycles and requester 0 valid -> no req_ready and no tx_en for those 20 cycles.
- Timeout: tx_busy tied to 0 after tx_en -> err_timeout pulses once, 4 cycles after WAIT_BUSY entry; state returns to IDLE and the next request is accepted.
- Reset mid-send: resetn low during WAIT_DONE -> next cycle grant=0, lock_owner=0, tx_en=0; after release, requester 0 has priority.
